ch376s_spi_master: RTL and testbench
====================================

Name: ch376s_spi_master

Overview:
Byte-level SPI master (mode 0, MSB first) between the CH376S bus-interface register block and the CH376S USB host chip. Accepts single-byte write/read strobes from the bus side and drives SCK/MOSI/CS. Implements the CH376S framing rule: CS is pulsed high before every command byte and held low across the following data bytes until an explicit release. Exposes `ready` and the last received byte for the bus side's status and data reads.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; minimum 1.
- CS_IDLE_CYCLES, 2: clk cycles CS is held high before a command byte; minimum 1.
- CMD_GAP_CYCLES, 24: post-command quiet time in clk cycles. Used only with CH376S_CMD_GAP_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr  in  1  1-cycle strobe: transmit `din`
- cmd  in  1  qualifies `wr`: 1 = command byte (CS gap first), 0 = data byte
- rd  in  1  1-cycle strobe: receive transfer, MOSI driven 0xFF
- release  in  1  1-cycle strobe: end frame, deassert CS
- din  in  8  byte to transmit, sampled with `wr`
- dout  out  8  byte captured by the last completed transfer
- ready  out  1  1 = idle, strobes accepted
- sck  out  1  SPI clock, idle low
- sdo  out  1  MOSI
- sdi  in  1  MISO
- sdcs  out  1  chip select, active low

Behaviour:
- Reset values: sdcs=1, sck=0, sdo=1, dout=0x00, ready=1, state=IDLE. Reset mid-transfer aborts; these values appear on the next cycle.
- Strobes are honoured only in IDLE with ready=1; otherwise they are ignored and not queued.
- Strobe priority in the same cycle: wr > rd > release.
- States: IDLE, CS_GAP, SHIFT, (CMD_GAP with macro).
- IDLE:
  - wr with cmd=1: latch din into the shift register; go to CS_GAP.
  - wr with cmd=0, or rd: latch din (or 0xFF for rd); go to SHIFT; sdcs driven 0.
  - release: sdcs=1 next cycle; stay in IDLE.
- CS_GAP: sdcs=1 for exactly CS_IDLE_CYCLES cycles, then sdcs=0 and go to SHIFT. Applied even if CS was already high.
- SHIFT timing:
  - Cycle after entry: sdo = bit7, sck=0.
  - Each bit is a CLK_DIV-cycle low half followed by a CLK_DIV-cycle high half.
  - sdi is sampled into the receive register on every sck rising edge.
  - sdo advances to the next bit on every falling edge.
  - After the 8th falling edge: dout ← received byte, ready=1, sdo=1, return to IDLE (same cycle). sdcs stays 0.
- Latency, measured from the strobe edge to ready=1:
  - Data or rd transfer: ready low for exactly 16*CLK_DIV cycles.
  - Command transfer: ready low for exactly CS_IDLE_CYCLES + 16*CLK_DIV cycles.
- dout changes only at transfer completion; it is stable while busy.
- sdcs stays low between bytes until release or the next command.
- A bit counter (3 bits) and a divider counter sized to CLK_DIV are used; the bit counter wraps from 7 to done, never beyond.

Optional Feature:
- Macro: CH376S_CMD_GAP_EN.
- Defined: after a command byte completes, enter CMD_GAP. For CMD_GAP_CYCLES cycles: ready=0, sck=0, sdcs=0, strobes ignored. Then go to IDLE. Command latency = CS_IDLE_CYCLES + 16*CLK_DIV + CMD_GAP_CYCLES. Data and rd transfers are unaffected.
- Not defined: no CMD_GAP state; ready returns immediately after the command byte; CMD_GAP_CYCLES is unused.

Test Plan:
All cases use CLK_DIV=2 and CS_IDLE_CYCLES=2 unless stated.
1. Reset held 3 cycles, then released → sdcs=1, sck=0, sdo=1, ready=1, dout=0x00; no sck toggles for 100 cycles.
2. wr, cmd=1, din=0x06 → sdcs high 2 cycles then low; sdo sampled at the 8 sck rising edges = 0,0,0,0,0,1,1,0; ready low exactly 34 cycles; sdcs remains 0 afterwards.
3. After case 2: wr, cmd=0, din=0x5A, then rd with slave driving 0xA5 on sdi → rd's sdo all 1s; dout=0xA5 on the cycle ready rises; dout is 0x00 (prior MISO) value held while busy.
4. release in IDLE → sdcs=1 next cycle. release, wr, or rd issued while busy → ignored: transfer completes unchanged and no second transfer starts. wr+rd in the same idle cycle → wr transfer (sdo follows din).
5. reset asserted after the 3rd sck rising edge of a transfer → next cycle sdcs=1, sck=0, ready=1, dout=0x00; a subsequent wr transfers correctly.
6. With CH376S_CMD_GAP_EN and CMD_GAP_CYCLES=24: command 0x06 → ready low 58 cycles with sck quiet during the last 24; a data wr right after still takes 32 cycles.

Source files
------------

// File: rtl/ch376s_spi_master_if.sv
// Bus-side strobe/status bundle of the CH376S SPI byte master.
// The master modport belongs to the register block; the slave modport belongs to the SPI engine.
interface ch376s_spi_master_if;
  logic       wr;
  logic       cmd;
  logic       rd;
  logic       release_cs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       ready;

  // Handshake: wr/rd/release_cs are one-cycle strobes, honoured only while ready=1
  // (priority wr > rd > release_cs); strobes seen while ready=0 are dropped, never queued.
  modport master (output wr, cmd, rd, release_cs, din, input dout, ready);
  modport slave  (input wr, cmd, rd, release_cs, din, output dout, ready);
endinterface

// File: rtl/ch376s_spi_master.sv
// Byte-level SPI mode-0 master for the CH376S: CS gap before command bytes, CS held low across data.
// Optional post-command quiet period enabled by defining CH376S_CMD_GAP_EN.
module ch376s_spi_master #(
  parameter int CLK_DIV        = 4,
  parameter int CS_IDLE_CYCLES = 2,
  parameter int CMD_GAP_CYCLES = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  ch376s_spi_master_if.slave    bus,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic                  sdcs,
  output logic [1:0]            state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CS_GAP  = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;
`ifdef CH376S_CMD_GAP_EN
  localparam logic [1:0] CMD_GAP = 2'd3;
`endif

  localparam int DW      = $clog2(CLK_DIV + 1);
  localparam int GAP_MAX = (CS_IDLE_CYCLES > CMD_GAP_CYCLES) ? CS_IDLE_CYCLES : CMD_GAP_CYCLES;
  localparam int GW      = $clog2(GAP_MAX + 1);

  logic [7:0]    sh;
  logic [7:0]    rx;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
`ifdef CH376S_CMD_GAP_EN
  logic          is_cmd;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sdcs     <= 1'b1;
      sck      <= 1'b0;
      sdo      <= 1'b1;
      bus.dout <= 8'h00;
      bus.ready <= 1'b1;
      sh       <= 8'h00;
      rx       <= 8'h00;
      bit_cnt  <= 3'd0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
`ifdef CH376S_CMD_GAP_EN
      is_cmd   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ready && bus.wr) begin
            sh        <= bus.din;
            bit_cnt   <= 3'd0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bus.ready <= 1'b0;
`ifdef CH376S_CMD_GAP_EN
            is_cmd    <= bus.cmd;
`endif
            if (bus.cmd) begin
              // CS is pulsed high before every command, even if already high
              state <= CS_GAP;
              sdcs  <= 1'b1;
            end else begin
              state <= SHIFT;
              sdcs  <= 1'b0;
              sdo   <= bus.din[7];
            end
          end else if (bus.ready && bus.rd) begin
            sh        <= 8'hFF;
            bit_cnt   <= 3'd0;
            div_cnt   <= '0;
            bus.ready <= 1'b0;
`ifdef CH376S_CMD_GAP_EN
            is_cmd    <= 1'b0;
`endif
            state     <= SHIFT;
            sdcs      <= 1'b0;
            sdo       <= 1'b1;
          end else if (bus.ready && bus.release_cs) begin
            sdcs <= 1'b1;
          end
        end

        CS_GAP: begin
          if (gap_cnt == GW'(CS_IDLE_CYCLES - 1)) begin
            state <= SHIFT;
            sdcs  <= 1'b0;
            sdo   <= sh[7];
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!sck) begin
              sck <= 1'b1;
              rx  <= {rx[6:0], sdi};
            end else begin
              sck <= 1'b0;
              if (bit_cnt == 3'd7) begin
                bus.dout <= rx;
                sdo      <= 1'b1;
`ifdef CH376S_CMD_GAP_EN
                if (is_cmd) begin
                  state   <= CMD_GAP;
                  gap_cnt <= '0;
                end else begin
                  state     <= IDLE;
                  bus.ready <= 1'b1;
                end
`else
                state     <= IDLE;
                bus.ready <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                sh      <= {sh[6:0], 1'b1};
                sdo     <= sh[6];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

`ifdef CH376S_CMD_GAP_EN
        CMD_GAP: begin
          if (gap_cnt == GW'(CMD_GAP_CYCLES - 1)) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ch376s_spi_master.sv
// Directed bench for ch376s_spi_master with CLK_DIV=2, CS_IDLE_CYCLES=2, CMD_GAP_CYCLES=24.
// Expected command latency grows by 24 cycles when CH376S_CMD_GAP_EN is defined.
module tb_ch376s_spi_master;

  logic       clk;
  logic       reset;
  logic       sck;
  logic       sdo;
  logic       sdi;
  logic       sdcs;
  logic [1:0] state;
  int         n_cmp;
  int         n_bad;

  ch376s_spi_master_if bus_if ();

  ch376s_spi_master #(.CLK_DIV(2), .CS_IDLE_CYCLES(2), .CMD_GAP_CYCLES(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .sck   (sck),
    .sdo   (sdo),
    .sdi   (sdi),
    .sdcs  (sdcs),
    .state (state)
  );

`ifdef CH376S_CMD_GAP_EN
  localparam int CMD_LAT   = 58;
  localparam int CMD_QUIET = 24;
`else
  localparam int CMD_LAT   = 34;
  localparam int CMD_QUIET = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one transfer and measures it; all samples are taken on negedge clk.
  task automatic xfer(input bit is_cmd, input bit is_rd, input bit both, input logic [7:0] d,
                      input logic [7:0] miso, input int inj,
                      output int lat, output logic [7:0] mosi, output int rises,
                      output int cs_hi, output int quiet, output bit dout_moved);
    logic [7:0] d0;
    bit         prev_sck;
    int         falls;
    lat = 0; mosi = 8'h00; rises = 0; cs_hi = 0; quiet = 0; dout_moved = 0; falls = 0;
    d0  = bus_if.dout;
    sdi = miso[7];
    @(negedge clk);
    bus_if.wr  = !is_rd || both;
    bus_if.rd  = is_rd || both;
    bus_if.cmd = is_cmd;
    bus_if.din = d;
    @(negedge clk);
    bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.cmd = 1'b0;
    prev_sck = 1'b0;
    while (bus_if.ready === 1'b0 && lat < 500) begin
      lat++;
      if (sdcs) cs_hi++;
      if (bus_if.dout !== d0) dout_moved = 1;
      if (sck && !prev_sck) begin
        mosi = {mosi[6:0], sdo};
        rises++;
        if (rises < 8) sdi = miso[7-rises];
      end
      if (!sck && prev_sck) falls++;
      if (falls == 8 && !sck) quiet++;
      prev_sck = sck;
      bus_if.release_cs = (lat == 5 && inj == 1);
      bus_if.wr         = (lat == 5 && inj == 2);
      bus_if.rd         = (lat == 5 && inj == 3);
      bus_if.din        = 8'h00;
      @(negedge clk);
      bus_if.release_cs = 1'b0; bus_if.wr = 1'b0; bus_if.rd = 1'b0;
    end
  endtask

  task automatic test_reset();
    int toggles;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (sdcs !== 1'b1) begin n_bad++; $display("FAIL reset_sdcs: got %b want 1", sdcs); end
    n_cmp++; if (sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", sck); end
    n_cmp++; if (sdo !== 1'b1) begin n_bad++; $display("FAIL reset_sdo: got %b want 1", sdo); end
    n_cmp++; if (bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus_if.ready); end
    n_cmp++; if (bus_if.dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", bus_if.dout); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    toggles = 0;
    repeat (100) begin
      @(negedge clk);
      if (sck !== 1'b0) toggles++;
    end
    n_cmp++; if (toggles !== 0) begin n_bad++; $display("FAIL reset_quiet: got %0d sck-high samples want 0", toggles); end
  endtask

  task automatic test_command();
    int lat, rises, cs_hi, quiet; logic [7:0] mosi; bit moved;
    xfer(1, 0, 0, 8'h06, 8'h00, 0, lat, mosi, rises, cs_hi, quiet, moved);
    n_cmp++; if (lat !== CMD_LAT) begin n_bad++; $display("FAIL cmd_latency: got %0d want %0d", lat, CMD_LAT); end
    n_cmp++; if (mosi !== 8'h06) begin n_bad++; $display("FAIL cmd_mosi: got %h want 06", mosi); end
    n_cmp++; if (rises !== 8) begin n_bad++; $display("FAIL cmd_rises: got %0d want 8", rises); end
    n_cmp++; if (cs_hi !== 2) begin n_bad++; $display("FAIL cmd_cs_gap: got %0d want 2", cs_hi); end
    n_cmp++; if (quiet !== CMD_QUIET) begin n_bad++; $display("FAIL cmd_quiet: got %0d want %0d", quiet, CMD_QUIET); end
    n_cmp++; if (sdcs !== 1'b0) begin n_bad++; $display("FAIL cmd_cs_after: got %b want 0", sdcs); end
    n_cmp++; if (bus_if.dout !== 8'h00) begin n_bad++; $display("FAIL cmd_dout: got %h want 00", bus_if.dout); end
  endtask

  task automatic test_data_read();
    int lat, rises, cs_hi, quiet; logic [7:0] mosi; bit moved;
    xfer(0, 0, 0, 8'h5A, 8'h00, 0, lat, mosi, rises, cs_hi, quiet, moved);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL data_latency: got %0d want 32", lat); end
    n_cmp++; if (mosi !== 8'h5A) begin n_bad++; $display("FAIL data_mosi: got %h want 5a", mosi); end
    n_cmp++; if (cs_hi !== 0) begin n_bad++; $display("FAIL data_cs: got %0d high samples want 0", cs_hi); end
    xfer(0, 1, 0, 8'h00, 8'hA5, 0, lat, mosi, rises, cs_hi, quiet, moved);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL rd_latency: got %0d want 32", lat); end
    n_cmp++; if (mosi !== 8'hFF) begin n_bad++; $display("FAIL rd_mosi: got %h want ff", mosi); end
    n_cmp++; if (bus_if.dout !== 8'hA5) begin n_bad++; $display("FAIL rd_dout: got %h want a5", bus_if.dout); end
    n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL rd_dout_stable: got %b want 0", moved); end
    n_cmp++; if (sdcs !== 1'b0) begin n_bad++; $display("FAIL rd_cs_after: got %b want 0", sdcs); end
  endtask

  task automatic test_strobes();
    int lat, rises, cs_hi, quiet, bad_idle; logic [7:0] mosi; bit moved;
    @(negedge clk);
    bus_if.release_cs = 1'b1;
    @(negedge clk);
    bus_if.release_cs = 1'b0;
    n_cmp++; if (sdcs !== 1'b1) begin n_bad++; $display("FAIL release_idle: got %b want 1", sdcs); end
    for (int inj = 1; inj <= 3; inj++) begin
      xfer(0, 0, 0, 8'hC6, 8'h39, inj, lat, mosi, rises, cs_hi, quiet, moved);
      n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL busy_latency%0d: got %0d want 32", inj, lat); end
      n_cmp++; if (mosi !== 8'hC6) begin n_bad++; $display("FAIL busy_mosi%0d: got %h want c6", inj, mosi); end
      n_cmp++; if (cs_hi !== 0) begin n_bad++; $display("FAIL busy_cs%0d: got %0d want 0", inj, cs_hi); end
      n_cmp++; if (bus_if.dout !== 8'h39) begin n_bad++; $display("FAIL busy_dout%0d: got %h want 39", inj, bus_if.dout); end
      bad_idle = 0;
      repeat (10) begin
        @(negedge clk);
        if (bus_if.ready !== 1'b1 || sck !== 1'b0 || sdcs !== 1'b0) bad_idle++;
      end
      n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL busy_no_second%0d: got %0d bad samples want 0", inj, bad_idle); end
    end
    xfer(0, 1, 1, 8'h3C, 8'h00, 0, lat, mosi, rises, cs_hi, quiet, moved);
    n_cmp++; if (mosi !== 8'h3C) begin n_bad++; $display("FAIL wr_over_rd: got %h want 3c", mosi); end
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL wr_over_rd_latency: got %0d want 32", lat); end
  endtask

  task automatic test_reset_abort();
    int lat, rises, cs_hi, quiet, guard; logic [7:0] mosi; bit moved, prev_sck;
    sdi = 1'b1;
    @(negedge clk);
    bus_if.wr = 1'b1; bus_if.cmd = 1'b0; bus_if.din = 8'h81;
    @(negedge clk);
    bus_if.wr = 1'b0;
    rises = 0; guard = 0; prev_sck = 1'b0;
    while (rises < 3 && guard < 200) begin
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
      guard++;
      if (rises < 3) @(negedge clk);
    end
    n_cmp++; if (rises !== 3) begin n_bad++; $display("FAIL abort_reach: got %0d rises want 3", rises); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (sdcs !== 1'b1) begin n_bad++; $display("FAIL abort_sdcs: got %b want 1", sdcs); end
    n_cmp++; if (sck !== 1'b0) begin n_bad++; $display("FAIL abort_sck: got %b want 0", sck); end
    n_cmp++; if (bus_if.ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", bus_if.ready); end
    n_cmp++; if (bus_if.dout !== 8'h00) begin n_bad++; $display("FAIL abort_dout: got %h want 00", bus_if.dout); end
    xfer(0, 0, 0, 8'hC3, 8'h3C, 0, lat, mosi, rises, cs_hi, quiet, moved);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL abort_next_latency: got %0d want 32", lat); end
    n_cmp++; if (mosi !== 8'hC3) begin n_bad++; $display("FAIL abort_next_mosi: got %h want c3", mosi); end
    n_cmp++; if (bus_if.dout !== 8'h3C) begin n_bad++; $display("FAIL abort_next_dout: got %h want 3c", bus_if.dout); end
  endtask

  task automatic test_back_to_back();
    int lat, rises, cs_hi, quiet; logic [7:0] mosi; bit moved;
    xfer(1, 0, 0, 8'h06, 8'h00, 0, lat, mosi, rises, cs_hi, quiet, moved);
    n_cmp++; if (lat !== CMD_LAT) begin n_bad++; $display("FAIL b2b_cmd_latency: got %0d want %0d", lat, CMD_LAT); end
    xfer(0, 0, 0, 8'h9E, 8'h71, 0, lat, mosi, rises, cs_hi, quiet, moved);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL b2b_data_latency: got %0d want 32", lat); end
    n_cmp++; if (mosi !== 8'h9E) begin n_bad++; $display("FAIL b2b_data_mosi: got %h want 9e", mosi); end
    n_cmp++; if (bus_if.dout !== 8'h71) begin n_bad++; $display("FAIL b2b_data_dout: got %h want 71", bus_if.dout); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; sdi = 1'b0;
    bus_if.wr = 1'b0; bus_if.cmd = 1'b0; bus_if.rd = 1'b0;
    bus_if.release_cs = 1'b0; bus_if.din = 8'h00;
    test_reset();
    test_command();
    test_data_read();
    test_strobes();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
